// File: rtl/audio_pkg.sv
// audio_pkg: shared types for the audio frame packer.
// Frame geometry, sample/frame typedefs, bank and output state enums.
package audio_pkg;

  localparam int FRAME_LEN   = 32;
  localparam int SAMPLE_W    = 16;
  localparam int ADDR_STRIDE = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [FRAME_LEN-1:0]     frame_t;

  typedef enum logic [1:0] {
    FREE,
    FILL,
    FULL
  } bank_state_t;

  typedef enum logic {
    IDLE,
    PRESENT
  } out_state_t;

endpackage

// File: rtl/audio_frame_bank.sv
// audio_frame_bank: one frame store with write index, FULL flag, tag.
// Ports: clr_i/fill_i/wr_i/data_i/rel_i/tag_i in; state/idx/frame/tag out.
// With PACKER_FLUSH_EN, pad_i zero-fills the tail and closes the frame.
module audio_frame_bank
  import audio_pkg::*;
#(
  parameter int FRAME_LEN = audio_pkg::FRAME_LEN,
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr_i,
  input  logic                                fill_i,
  input  logic                                wr_i,
  input  logic [SAMPLE_W-1:0]                 data_i,
`ifdef PACKER_FLUSH_EN
  input  logic                                pad_i,
`endif
  input  logic                                rel_i,
  input  logic [31:0]                         tag_i,
  output bank_state_t                         state_o,
  output logic [IDX_W-1:0]                    idx_o,
  output logic [FRAME_LEN-1:0][SAMPLE_W-1:0]  frame_o,
  output logic [31:0]                         tag_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] mem_q, mem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full_q, full_d;
  logic [31:0]      tag_q, tag_d;
  logic             close;
`ifdef PACKER_FLUSH_EN
  int               pad_from;
`endif

  always_comb begin
    mem_d  = mem_q;
    idx_d  = idx_q;
    full_d = full_q;
    tag_d  = tag_q;
    close  = 1'b0;
    if (wr_i) begin
      mem_d[idx_q] = data_i;
      idx_d        = idx_q + IDX_W'(1);
      close        = (idx_q == LAST);
    end
`ifdef PACKER_FLUSH_EN
    // pad starts after the slot written this cycle, if any
    pad_from = int'(idx_q) + (wr_i ? 1 : 0);
    if (pad_i) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (k >= pad_from) mem_d[k] = '0;
      end
      close = 1'b1;
    end
`endif
    if (close) begin
      full_d = 1'b1;
      tag_d  = tag_i;
      idx_d  = '0;
    end
    if (rel_i) full_d = 1'b0;
    if (clr_i) begin
      full_d = 1'b0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      idx_q  <= idx_d;
      full_q <= full_d;
      tag_q  <= tag_d;
    end
  end

  assign state_o = full_q ? FULL : (fill_i ? FILL : FREE);
  assign idx_o   = idx_q;
  assign frame_o = mem_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/audio_frame_packer.sv
// audio_frame_packer: packs samples into ping-pong frames for the chain.
// Ports: start/base_address, sample_valid/sample_in/sample_ready, flush,
// next_module_ready/done/address_out/audio_out. Macro: PACKER_FLUSH_EN.
module audio_frame_packer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN   = audio_pkg::FRAME_LEN,
  parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
  parameter int ADDR_STRIDE = audio_pkg::ADDR_STRIDE
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [31:0]                                base_address,
  input  logic                                       sample_valid,
  input  logic signed [SAMPLE_W-1:0]                 sample_in,
  output logic                                       sample_ready,
  input  logic                                       flush,
  input  logic                                       next_module_ready,
  output logic                                       done,
  output logic [31:0]                                address_out,
  output logic signed [FRAME_LEN-1:0][SAMPLE_W-1:0]  audio_out
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  bank_state_t                        st    [2];
  logic [IDX_W-1:0]                   idx   [2];
  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] frame [2];
  logic [31:0]                        tag   [2];
  logic                               wr    [2];
  logic                               rel   [2];
`ifdef PACKER_FLUSH_EN
  logic                               pad   [2];
`else
  logic                               unused_flush;
  assign unused_flush = flush;
`endif

  logic        fill_sel_q, fill_sel_d;
  logic        fill_ok_q, fill_ok_d;
  logic [31:0] next_addr_q, next_addr_d;
  out_state_t  os_q, os_d;
  logic        pres_q, pres_d;

  logic acc, pad_ev, cmpl, xfer;
  logic other, other_free, pres_oth;

  // accept / complete / transfer events; start masks all of them
  always_comb begin
    acc = sample_valid & fill_ok_q & ~start;
`ifdef PACKER_FLUSH_EN
    pad_ev = flush & fill_ok_q & ~start
           & ((idx[fill_sel_q] != '0) | acc);
`else
    pad_ev = 1'b0;
`endif
    cmpl = (acc & (idx[fill_sel_q] == LAST)) | pad_ev;
    xfer = (os_q == PRESENT) & next_module_ready & ~start;
    for (int b = 0; b < 2; b++) begin
      wr[b]  = acc & (fill_sel_q == 1'(b));
      rel[b] = xfer & (pres_q == 1'(b));
`ifdef PACKER_FLUSH_EN
      pad[b] = pad_ev & (fill_sel_q == 1'(b));
`endif
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    audio_frame_bank #(
      .FRAME_LEN (FRAME_LEN),
      .SAMPLE_W  (SAMPLE_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (start),
      .fill_i  (fill_ok_q & (fill_sel_q == 1'(b))),
      .wr_i    (wr[b]),
      .data_i  (sample_in),
`ifdef PACKER_FLUSH_EN
      .pad_i   (pad[b]),
`endif
      .rel_i   (rel[b]),
      .tag_i   (next_addr_q),
      .state_o (st[b]),
      .idx_o   (idx[b]),
      .frame_o (frame[b]),
      .tag_o   (tag[b])
    );
  end

  // fill-role arbitration and address tagging
  always_comb begin
    fill_sel_d  = fill_sel_q;
    fill_ok_d   = fill_ok_q;
    next_addr_d = next_addr_q;
    other       = ~fill_sel_q;
    // the other bank counts as free if it is emptied this very cycle
    other_free  = (st[other] != FULL) | (xfer & (pres_q == other));
    if (start) begin
      fill_sel_d  = 1'b0;
      fill_ok_d   = 1'b1;
      next_addr_d = base_address;
    end else if (fill_ok_q) begin
      if (cmpl) begin
        next_addr_d = next_addr_q + 32'(ADDR_STRIDE);
        if (other_free) fill_sel_d = other;
        else            fill_ok_d  = 1'b0;
      end
    end else if (xfer) begin
      fill_sel_d = pres_q;
      fill_ok_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sel_q  <= 1'b0;
      fill_ok_q   <= 1'b1;
      next_addr_q <= '0;
    end else begin
      fill_sel_q  <= fill_sel_d;
      fill_ok_q   <= fill_ok_d;
      next_addr_q <= next_addr_d;
    end
  end

  // output FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q   <= IDLE;
      pres_q <= 1'b0;
    end else begin
      os_q   <= os_d;
      pres_q <= pres_d;
    end
  end

  // output FSM: next state
  always_comb begin
    os_d     = os_q;
    pres_d   = pres_q;
    pres_oth = ~pres_q;
    if (start) begin
      os_d = IDLE;
    end else begin
      unique case (os_q)
        IDLE: begin
          if (cmpl) begin
            os_d   = PRESENT;
            pres_d = fill_sel_q;
          end
        end
        PRESENT: begin
          if (xfer) begin
            // a frame closing now is always in the non-presented bank
            if ((st[pres_oth] == FULL) | cmpl) pres_d = pres_oth;
            else                               os_d   = IDLE;
          end
        end
      endcase
    end
  end

  // output FSM: outputs
  always_comb begin
    done         = (os_q == PRESENT);
    address_out  = tag[pres_q];
    audio_out    = frame[pres_q];
    sample_ready = fill_ok_q;
  end

endmodule

// File: tb/tb_audio_frame_packer.sv
// tb_audio_frame_packer: directed self-checking bench for the packer.
// Covers reset, handshake, back-pressure, restart, wrap and flush.
module tb_audio_frame_packer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [31:0] base_address;
  logic sample_valid;
  logic signed [15:0] sample_in;
  logic sample_ready;
  logic flush;
  logic next_module_ready;
  logic done;
  logic [31:0] address_out;
  logic signed [31:0][15:0] audio_out;

  int checks = 0;
  int failures = 0;
  logic [31:0][15:0] exp_f;
  logic bubble;
  logic dropped;

  always #5 clk = ~clk;

  audio_frame_packer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_address      (base_address),
    .sample_valid      (sample_valid),
    .sample_in         (sample_in),
    .sample_ready      (sample_ready),
    .flush             (flush),
    .next_module_ready (next_module_ready),
    .done              (done),
    .address_out       (address_out),
    .audio_out         (audio_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [511:0] exp);
    checks++;
    assert (audio_out === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, audio_out, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_address = b;
    sample_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_in = v;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_address = '0;
    sample_valid = 1'b0;
    sample_in = '0;
    flush = 1'b0;
    next_module_ready = 1'b0;
    tick();
    tick();
    chk("rst_done", done, 0);
    chk("rst_addr", address_out, 0);
    chk_frame("rst_audio", '0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", sample_ready, 1);

    // ramp 0..31, downstream always ready
    do_start(32'h1000);
    next_module_ready = 1'b1;
    for (int i = 0; i < 31; i++) send(16'(i));
    chk("ramp_done_early", done, 0);
    send(16'd31);
    sample_valid = 1'b0;
    chk("ramp_done", done, 1);
    chk("ramp_addr", address_out, 32'h1000);
    for (int k = 0; k < 32; k++) exp_f[k] = 16'(k);
    chk_frame("ramp_audio", exp_f);
    tick();
    chk("ramp_xfer", done, 0);

    // back-pressure: both banks fill, ready drops
    do_start(32'h1000);
    next_module_ready = 1'b0;
    for (int i = 0; i < 64; i++) send(16'(100 + i));
    chk("bp_ready_low", sample_ready, 0);
    chk("bp_done", done, 1);
    sample_in = 16'd164;
    tick();
    tick();
    chk("bp_addr_hold", address_out, 32'h1000);
    chk("bp_audio_hold", audio_out[0], 32'd100);
    next_module_ready = 1'b1;
    tick();
    next_module_ready = 1'b0;
    chk("bp_done2", done, 1);
    chk("bp_addr2", address_out, 32'h1040);
    chk("bp_audio2", audio_out[0], 32'd132);
    chk("bp_ready_back", sample_ready, 1);
    for (int i = 0; i < 32; i++) send(16'(164 + i));
    sample_valid = 1'b0;
    chk("bp_ready_low2", sample_ready, 0);
    chk("bp_addr2_hold", address_out, 32'h1040);
    next_module_ready = 1'b1;
    tick();
    chk("bp_addr3", address_out, 32'h1080);
    chk("bp_audio3", audio_out[31], 32'd195);
    tick();
    chk("bp_idle", done, 0);
    next_module_ready = 1'b0;

    // continuous stream, ready pulsed as each next frame closes
    do_start(32'h3000);
    bubble = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 96; i++) begin
      if (!sample_ready) bubble = 1'b1;
      next_module_ready = (i == 63) || (i == 95);
      send(16'(i));
      if (i >= 31 && !done) dropped = 1'b1;
    end
    sample_valid = 1'b0;
    next_module_ready = 1'b0;
    chk("cont_no_bubble", bubble, 0);
    chk("cont_done_held", dropped, 0);
    chk("cont_addr", address_out, 32'h3080);
    chk("cont_audio", audio_out[0], 32'd64);
    next_module_ready = 1'b1;
    tick();
    chk("cont_idle", done, 0);
    next_module_ready = 1'b0;

    // restart discards a partial frame
    do_start(32'h1000);
    for (int i = 0; i < 10; i++) send(16'h5555);
    do_start(32'h2000);
    for (int i = 0; i < 32; i++) send(16'hFFFF);
    sample_valid = 1'b0;
    chk("rs_done", done, 1);
    chk("rs_addr", address_out, 32'h2000);
    for (int k = 0; k < 32; k++) exp_f[k] = 16'hFFFF;
    chk_frame("rs_audio", exp_f);
    next_module_ready = 1'b1;
    tick();
    chk("rs_no_stale", done, 0);
    next_module_ready = 1'b0;

    // address wrap
    do_start(32'hFFFF_FFC0);
    for (int i = 0; i < 64; i++) send(16'(i));
    sample_valid = 1'b0;
    chk("wrap_addr0", address_out, 32'hFFFF_FFC0);
    next_module_ready = 1'b1;
    tick();
    chk("wrap_addr1", address_out, 32'h0000_0000);
    tick();
    chk("wrap_idle", done, 0);
    next_module_ready = 1'b0;

    // flush of a 5-sample partial frame
    do_start(32'h4000);
    for (int i = 0; i < 5; i++) send(16'h7FFF);
    sample_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef PACKER_FLUSH_EN
    chk("fl_done", done, 1);
    chk("fl_addr", address_out, 32'h4000);
    exp_f = '0;
    for (int k = 0; k < 5; k++) exp_f[k] = 16'h7FFF;
    chk_frame("fl_audio", exp_f);
`else
    chk("fl_ignored", done, 0);
`endif

    // asynchronous reset drops a presented frame at once
    do_start(32'h5000);
    for (int i = 0; i < 32; i++) send(16'(i));
    sample_valid = 1'b0;
    chk("ar_done_pre", done, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_done", done, 0);
    chk("ar_addr", address_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_ready", sample_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_frame_packer.md
# audio_frame_packer

Source end of the effect-chain frame handshake. Accepts a serial stream of 16-bit signed samples, packs them into 32-sample frames in a ping-pong buffer, tags each frame with a byte address, and presents it to the first effect stage using the `done` / `next_module_ready` handshake. Sits between the sample source (DMA/memory reader) and the head of the effect chain.

## Interface

**Parameters**
- `FRAME_LEN`, default 32: samples per frame.
- `SAMPLE_W`, default 16: sample width, two's complement.
- `ADDR_STRIDE`, default 64: byte address increment per frame.

**Ports**
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  synchronous pulse: clear buffers and load `base_address`.
- `base_address`  in  32  address of first frame, sampled on `start`.
- `sample_valid`  in  1  `sample_in` valid.
- `sample_in`  in  signed 16  input sample.
- `sample_ready`  out  1  packer can accept a sample this cycle.
- `flush`  in  1  pad partial frame (only with `PACKER_FLUSH_EN`).
- `next_module_ready`  in  1  downstream `ready_for_data`.
- `done`  out  1  frame presented, held until transfer.
- `address_out`  out  32  address tag of presented frame.
- `audio_out`  out  signed 16 × 32  presented frame; index 0 is the earliest sample.

## Operation

- Uses two frame banks, A and B. Each bank is either FILL, FULL or FREE.
- One bank is the fill bank. It has a write index `wr_idx` that runs from 0 to 31.
- A sample is accepted when `sample_valid & sample_ready`:
  - the sample is written to `fill_bank[wr_idx]`;
  - `wr_idx` increments.
- On the 32nd accept:
  - the bank becomes FULL and takes tag `next_addr`;
  - `next_addr += ADDR_STRIDE`, wrapping modulo 2^32;
  - `wr_idx` returns to 0;
  - the fill role moves to the other bank if it is FREE.
- Output port states:
  - **IDLE**: `done=0`.
  - **PRESENT**: `done=1`, showing the oldest FULL bank.
- A transfer happens on a cycle with `done & next_module_ready`. On transfer:
  - the presented bank becomes FREE;
  - if the other bank is FULL, it is presented the next cycle (`done` stays 1);
  - otherwise the state goes to IDLE.
- `sample_ready = 1` exactly when a fill bank exists, i.e. at least one bank is not FULL.
- `audio_out` and `address_out` are stable for the whole time `done=1`.
- `start` clears both banks to FREE and sets `wr_idx=0`, `done=0`, `next_addr=base_address`. A partial frame is discarded. `start` overrides any sample accept or transfer in the same cycle.

## Timing

- Reset values:
  - `done=0`, `address_out=0`, all `audio_out=0`;
  - `sample_ready=1` from the first edge after reset release;
  - `next_addr=0`.
- Latency: `done` rises one cycle after the 32nd sample is accepted.
- Throughput: one sample per cycle sustained while downstream accepts at least one frame per 32 cycles.
- 32nd accept and transfer in the same cycle:
  - the freed bank becomes the fill bank immediately;
  - `sample_ready` stays 1 with no bubble.
- Both banks FULL:
  - `sample_ready=0`;
  - `sample_ready` returns to 1 in the cycle after the transfer.
- `next_module_ready` is ignored while `done=0`.
- Reset asserted mid-frame discards all data immediately.

## Configuration

- `PACKER_FLUSH_EN` defined:
  - a `flush` pulse with `wr_idx > 0` zero-fills slots `wr_idx..31`;
  - the bank is marked FULL exactly as on a 32nd accept.
- `flush` edge cases with the macro defined:
  - with `wr_idx = 0`, `flush` has no effect;
  - `flush` together with a `sample_valid` accept: the sample is written first, then padding applies;
  - if no bank is FREE to take over filling, padding completes and `sample_ready` drops as usual.
- `PACKER_FLUSH_EN` undefined: the `flush` port exists but is ignored, and no padding logic is synthesized.

## Structure

- Shared package `audio_pkg`:
  - `FRAME_LEN`, `SAMPLE_W`, `ADDR_STRIDE`;
  - typedef `sample_t` (logic signed [15:0]);
  - typedef `frame_t` (sample_t [FRAME_LEN-1:0]);
  - enum `bank_state_t` {FREE, FILL, FULL}.
- Sub-module `audio_frame_bank`: one frame store with write port and index, FULL flag and address tag. It is instantiated twice.
- Top level holds the bank arbitration, the output state machine and `next_addr`.

## Test plan

- Stream ramp 0..31 with `next_module_ready=1`, after `start` with `base_address=0x1000` → `done` high at cycle 33; `audio_out[k]=k`; `address_out=0x1000`; transfer in the same cycle.
- Stream 96 samples with `next_module_ready=0` → `sample_ready` drops after sample 64; the first frame is held, tag `0x1000`. Raise ready → second frame tag `0x1040` presented the next cycle; `sample_ready` returns to 1.
- Continuous stream with ready pulsed at each frame completion → no `sample_ready` bubble; `done` stays continuously high across back-to-back frames.
- 10 samples, then `start` with `base_address=0x2000`, then 32 samples of `-1` → first frame tag `0x2000`, all `0xFFFF`; the old data never appears.
- `base_address=0xFFFFFFC0`, two frames → tags `0xFFFFFFC0`, then `0x00000000`.
- With `PACKER_FLUSH_EN`: 5 samples of 0x7FFF, then `flush` → frame presented with slots 0–4 = 0x7FFF and slots 5–31 = 0. Without the macro: no frame, `done=0`.
